phase_delay_driver: RTL

Multi-channel square-wave generator for the speaker array. It consumes the single-cycle tick from the timer stage and keeps a shared phase counter. From that counter it drives CHANNELS speaker outputs. Each output has a programmable phase offset, which lets the array steer its beam. Delay settings are loaded through a valid/ready port into shadow registers and take effect only at a period boundary, so the outputs never glitch mid-period.

---
 rtl/phase_delay_driver.sv | 116 +++++++++++
 1 files changed

// File: rtl/phase_delay_driver.sv
// Shared-phase square-wave generator for a speaker array with per-channel phase offsets.
// Delay writes go to shadow registers and commit to every channel together at the period wrap.
module phase_delay_driver #(
  parameter int CHANNELS    = 8,
  parameter int HALF_PERIOD = 4,
  parameter int DELAY_W     = $clog2(2 * HALF_PERIOD),
  parameter int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_tick,
  input  logic                i_en,
  input  logic                i_cfg_valid,
  output logic                o_cfg_ready,
  input  logic [CH_W-1:0]     i_cfg_ch,
  input  logic [DELAY_W:0]    i_cfg_delay,
  output logic                o_cfg_pending,
  output logic                o_sync,
  output logic [CHANNELS-1:0] o_spk
);

  localparam int                 PERIOD    = 2 * HALF_PERIOD;
  localparam logic [DELAY_W-1:0] PHASE_MAX = DELAY_W'(PERIOD - 1);
  localparam logic [DELAY_W:0]   DELAY_MAX = (DELAY_W + 1)'(PERIOD - 1);
  localparam logic [DELAY_W-1:0] HALF      = DELAY_W'(HALF_PERIOD);
  localparam logic [CH_W:0]      CH_LIMIT  = (CH_W + 1)'(CHANNELS);

  logic [DELAY_W-1:0]  r_phase;
  logic [DELAY_W-1:0]  r_shadow [CHANNELS];
  logic [DELAY_W-1:0]  r_active [CHANNELS];
  logic [CHANNELS-1:0] r_spk;
  logic                r_sync;
  logic                r_ready;
  logic                r_pending;

  logic                w_wrap;
  logic                w_accept;
  logic                w_ch_ok;
  logic                w_write;
  logic [DELAY_W-1:0]  w_delay_clamped;
  logic [DELAY_W-1:0]  w_phase_next;
  logic [CHANNELS-1:0] w_sel;
  logic [CHANNELS-1:0] w_spk_next;

  assign w_wrap   = i_en && i_tick && (r_phase == PHASE_MAX);
  assign w_accept = i_cfg_valid && r_ready;
  assign w_ch_ok  = ({1'b0, i_cfg_ch} < CH_LIMIT);
  assign w_write  = w_accept && w_ch_ok;

  assign w_delay_clamped = (i_cfg_delay > DELAY_MAX) ? PHASE_MAX : i_cfg_delay[DELAY_W-1:0];

  // PERIOD is a power of two, so the DELAY_W-bit increment wraps on its own.
  always_comb begin
    w_phase_next = r_phase;
    if (!i_en) begin
      w_phase_next = '0;
    end else if (i_tick) begin
      w_phase_next = r_phase + 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [DELAY_W-1:0] w_rel;

      assign w_sel[gi]      = w_write && (i_cfg_ch == CH_W'(gi));
      assign w_rel          = r_phase - r_active[gi];
      assign w_spk_next[gi] = i_en && (w_rel < HALF);
    end
  endgenerate

  // Commit reads the pre-write shadow, so a write on the wrap edge waits for the next wrap.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_shadow[c] <= '0;
        r_active[c] <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (w_wrap) begin
          r_active[c] <= r_shadow[c];
        end
        if (w_sel[c]) begin
          r_shadow[c] <= w_delay_clamped;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_phase   <= '0;
      r_spk     <= '0;
      r_sync    <= 1'b0;
      r_ready   <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_ready <= 1'b1;
      r_phase <= w_phase_next;
      r_spk   <= w_spk_next;
      r_sync  <= w_wrap;
      if (w_write) begin
        r_pending <= 1'b1;
      end else if (w_wrap) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign o_cfg_ready   = r_ready;
  assign o_cfg_pending = r_pending;
  assign o_sync        = r_sync;
  assign o_spk         = r_spk;

endmodule
